// File: rtl/wide_add_sequencer_if.sv
// Request, response and shared-adder signals of the wide add/sub sequencer.
// The master side is the requester/consumer/adder environment; the slave side is the sequencer.
interface wide_add_sequencer_if #(
   parameter int unsigned WORDS = 4
);
   localparam int unsigned W = 16 * WORDS;

   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_cin;
   logic          req_sub;

   logic [15:0]   add_a;
   logic [15:0]   add_b;
   logic          add_cin;
   logic [15:0]   add_sum;
   logic          add_cout;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_sum;
   logic          rsp_cout;

   modport master (
      output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready, add_sum, add_cout,
      input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready, add_sum, add_cout,
      output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// Word-serial WORDS x 16-bit add/subtract on one shared external 16-bit adder,
// least significant word first, carry registered between words.
module wide_add_sequencer #(
   parameter int unsigned WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   wide_add_sequencer_if.slave bus
);
   localparam int unsigned    W        = 16 * WORDS;
   localparam int unsigned    IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     res_q, res_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [15:0]      add_a_q, add_a_d;
   logic [15:0]      add_b_q, add_b_d;
   logic             add_cin_q, add_cin_d;

   // Adder ports are registered one cycle ahead so they present word idx during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      add_a_d     = '0;
      add_b_d     = '0;
      add_cin_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               // Subtraction is A + ~B + 1; req_cin is irrelevant then.
               a_d         = bus.req_a;
               b_d         = bus.req_sub ? ~bus.req_b : bus.req_b;
               carry_d     = bus.req_sub | bus.req_cin;
               idx_d       = '0;
               res_d       = '0;
               add_a_d     = a_d[15:0];
               add_b_d     = b_d[15:0];
               add_cin_d   = carry_d;
               req_ready_d = 1'b0;
               state_d     = RUN;
            end
         end

         RUN: begin
            res_d[32'(idx_q) * 16 +: 16] = bus.add_sum;
            carry_d                       = bus.add_cout;
            if (idx_q == IDX_LAST) begin
               rsp_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d     = idx_q + IDX_W'(1);
               add_a_d   = a_q[32'(idx_d) * 16 +: 16];
               add_b_d   = b_q[32'(idx_d) * 16 +: 16];
               add_cin_d = bus.add_cout;
            end
         end

         DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = res_q;
   assign bus.rsp_cout  = carry_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cin   = add_cin_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer with a behavioural 16-bit adder in place
// of the external carry_select_adder16.
module tb_wide_add_sequencer;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 16 * WORDS;

   typedef struct packed {
      logic         cout;
      logic [W-1:0] sum;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   rdy_mode = 0;   // 0: ready held high, 1: random, 2: held low
   rsp_t sb[$];

   always #5 clk = ~clk;

   wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

   wide_add_sequencer #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign {bus.add_cout, bus.add_sum} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the oldest expectation on every response handshake.
   initial begin
      rsp_t exp;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp_unexpected: got 0x%0h, want no response", bus.rsp_sum);
            end else begin
               exp = sb.pop_front();
               check("rsp_sum", 65'(bus.rsp_sum), 65'(exp.sum));
               check("rsp_cout", 65'(bus.rsp_cout), 65'(exp.cout));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1, "watchdog expired");
   end

   // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic exp_cout, input logic [W-1:0] exp_sum);
      int   n;
      logic acc;
      rsp_t e;
      e.cout = exp_cout;
      e.sum  = exp_sum;
      sb.push_back(e);
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_cin   = cin;
      bus.req_sub   = sub;
      bus.req_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      bus.req_valid = 1'b0;
      if (!acc) check("accept_timeout", 65'(0), 65'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.req_ready !== 1'b1) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", 65'(sb.size()), 65'(0));
      #1;
   endtask

   initial begin
      int            n;
      logic [W-1:0]  a, b, nb;
      logic          cin, sub;
      logic [64:0]   ref_sum;

      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = 1'b0;
      bus.req_sub   = 1'b0;

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 65'(bus.req_ready), 65'(1));
      check("rst_rsp_valid", 65'(bus.rsp_valid), 65'(0));
      check("rst_rsp_sum",   65'(bus.rsp_sum),   65'(0));
      check("rst_rsp_cout",  65'(bus.rsp_cout),  65'(0));
      check("rst_add_ports", 65'({bus.add_cin, bus.add_b, bus.add_a}), 65'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: simple add and latency / re-acceptance timing
      send(64'h1, 64'h2, 1'b0, 1'b0, 1'b0, 64'h3);
      check("t1_ready_in_run", 65'(bus.req_ready), 65'(0));
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.rsp_valid !== 1'b1 && n < 20);
      check("t1_latency", 65'(n), 65'(WORDS));
      check("t1_ready_in_done", 65'(bus.req_ready), 65'(0));
      @(posedge clk);
      #1;
      check("t1_ready_next", 65'(bus.req_ready), 65'(1));
      drain();

      // 2: all-ones + carry-in ripples through every word
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0);
      for (int i = 0; i < int'(WORDS); i++) begin
         @(negedge clk);
         check("t2_add_cin", 65'(bus.add_cin), 65'(1));
      end
      @(negedge clk);
      check("t2_done_valid", 65'(bus.rsp_valid), 65'(1));
      check("t2_done_add_idle", 65'({bus.add_cin, bus.add_b, bus.add_a}), 65'(0));
      @(posedge clk);
      drain();

      // 3: subtraction, with and without borrow (cin ignored in sub mode)
      send(64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_FFFF);
      send(64'h0, 64'h1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      drain();

      // 4: result holds while consumer stalls; new requests are not accepted
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0,
           64'h2345_6789_ABCD_F001);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      bus.req_a     = 64'h5;
      bus.req_b     = 64'h5;
      bus.req_cin   = 1'b0;
      bus.req_sub   = 1'b0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_valid_hold", 65'(bus.rsp_valid), 65'(1));
         check("t4_sum_hold",   65'(bus.rsp_sum),   65'(64'h2345_6789_ABCD_F001));
         check("t4_cout_hold",  65'(bus.rsp_cout),  65'(0));
         check("t4_no_ready",   65'(bus.req_ready), 65'(0));
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rdy_mode      = 0;
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("t4_no_queued_req", 65'({bus.req_ready, bus.rsp_valid}), 65'(2'b10));

      // 5: reset in the second RUN cycle aborts the operation
      send(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0, 1'b0,
           1'b1, 64'h0001_0001_0001_0000);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      check("t5_rsp_valid", 65'(bus.rsp_valid), 65'(0));
      check("t5_req_ready", 65'(bus.req_ready), 65'(1));
      check("t5_add_ports", 65'({bus.add_cin, bus.add_b, bus.add_a}), 65'(0));
      check("t5_rsp_sum",   65'(bus.rsp_sum),   65'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(64'd5, 64'd7, 1'b0, 1'b0, 1'b0, 64'd12);
      drain();

      // 6: random back-to-back traffic against a 65-bit reference
      rdy_mode = 1;
      for (int i = 0; i < 100; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         if (i % 10 == 0) a = '1;
         if (i % 10 == 5) b = '0;
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         nb  = sub ? ~b : b;
         ref_sum = 65'(a) + 65'(nb) + 65'(sub | cin);
         send(a, b, cin, sub, ref_sum[64], ref_sum[63:0]);
      end
      rdy_mode = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
